// File: rtl/display_buf_arbiter.sv
// Single-port display RAM arbiter: LCD scan-out reader A has priority, updater B has a starvation guard.
// Optional statistics counters are compiled in when DBUF_ARB_STATS_EN is defined.
module display_buf_arbiter #(
    parameter  int LEN        = 12800,
    parameter  int WIDTH      = 8,
    parameter  int RD_LAT     = 2,
    parameter  int STARVE_MAX = 8,
    localparam int AW         = $clog2(LEN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_req,
    input  logic [AW-1:0]    a_addr,
    output logic             a_gnt,
    output logic             a_rvalid,
    output logic [WIDTH-1:0] a_rdata,
    input  logic             b_req,
    input  logic             b_we,
    input  logic [AW-1:0]    b_addr,
    input  logic [WIDTH-1:0] b_wdata,
    output logic             b_gnt,
    output logic             b_rvalid,
    output logic [WIDTH-1:0] b_rdata,
    output logic [AW-1:0]    mem_addr,
    output logic [WIDTH-1:0] mem_din,
    output logic             mem_we,
`ifdef DBUF_ARB_STATS_EN
    input  logic             stat_clr,
    output logic [15:0]      stat_conflicts,
    output logic [15:0]      stat_forced,
`endif
    input  logic [WIDTH-1:0] mem_dout
);

    localparam logic [7:0] SMAX = 8'(STARVE_MAX);

    logic             force_b;
    logic             gnt_a_d;
    logic             gnt_b_d;
    logic [7:0]       streak_d;
    logic [7:0]       streak_q;
    logic             a_gnt_q;
    logic             b_gnt_q;
    logic             mem_we_q;
    logic [AW-1:0]    mem_addr_q;
    logic [WIDTH-1:0] mem_din_q;
    logic [RD_LAT-1:0] vld_q;
    logic [RD_LAT-1:0] own_b_q;
    logic [WIDTH-1:0] a_hold_q;
    logic [WIDTH-1:0] b_hold_q;

    assign force_b = a_req && b_req && (streak_q == SMAX);
    assign gnt_a_d = a_req && !force_b;
    assign gnt_b_d = b_req && !gnt_a_d;

    always_comb begin
        streak_d = streak_q;
        if (!b_req || gnt_b_d) begin
            streak_d = '0;
        end else if (gnt_a_d && streak_q != SMAX) begin
            streak_d = streak_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            streak_q   <= '0;
            a_gnt_q    <= 1'b0;
            b_gnt_q    <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            vld_q      <= '0;
            own_b_q    <= '0;
            a_hold_q   <= '0;
            b_hold_q   <= '0;
        end else begin
            streak_q <= streak_d;
            a_gnt_q  <= gnt_a_d;
            b_gnt_q  <= gnt_b_d;
            mem_we_q <= gnt_b_d && b_we;
            if (gnt_a_d) begin
                mem_addr_q <= a_addr;
            end else if (gnt_b_d) begin
                mem_addr_q <= b_addr;
            end
            if (gnt_b_d) begin
                mem_din_q <= b_wdata;
            end
            // Owner tag follows the access through the RAM read latency
            vld_q[0]   <= a_gnt_q || (b_gnt_q && !mem_we_q);
            own_b_q[0] <= b_gnt_q;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i]   <= vld_q[i-1];
                own_b_q[i] <= own_b_q[i-1];
            end
            if (a_rvalid) begin
                a_hold_q <= mem_dout;
            end
            if (b_rvalid) begin
                b_hold_q <= mem_dout;
            end
        end
    end

    assign a_gnt    = a_gnt_q;
    assign b_gnt    = b_gnt_q;
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign a_rvalid = vld_q[RD_LAT-1] && !own_b_q[RD_LAT-1];
    assign b_rvalid = vld_q[RD_LAT-1] && own_b_q[RD_LAT-1];
    assign a_rdata  = a_rvalid ? mem_dout : a_hold_q;
    assign b_rdata  = b_rvalid ? mem_dout : b_hold_q;

`ifdef DBUF_ARB_STATS_EN
    logic [15:0] conf_q;
    logic [15:0] forced_q;

    always_ff @(posedge clk) begin
        if (!rst_n || stat_clr) begin
            conf_q   <= '0;
            forced_q <= '0;
        end else begin
            if (a_req && b_req && conf_q != 16'hFFFF) begin
                conf_q <= conf_q + 16'd1;
            end
            if (force_b && forced_q != 16'hFFFF) begin
                forced_q <= forced_q + 16'd1;
            end
        end
    end

    assign stat_conflicts = conf_q;
    assign stat_forced    = forced_q;
`endif

endmodule
